// File: rtl/imem_access_arbiter.sv
// Two-port arbiter in front of a single registered-read instruction memory.
// Fetch (read-only) and loader (read/write) accesses are serialised as ISSUE -> CAPTURE.
module imem_access_arbiter #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 64,
    parameter bit LOADER_PRIO = 1'b0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_ack,
    output logic [DATA_W-1:0] l_rdata,
    output logic              mem_E,
    output logic              mem_RW,
    output logic [63:0]       mem_address,
    output logic [DATA_W-1:0] mem_dataIn,
    input  logic [DATA_W-1:0] mem_dataOut,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    typedef enum logic {
        PORT_F = 1'b0,
        PORT_L = 1'b1
    } port_t;

    state_t            state, state_nx;
    port_t             last_gnt, last_gnt_nx;
    logic              wr_q, wr_nx;
    logic              f_ack_nx, l_ack_nx;
    logic [DATA_W-1:0] f_rdata_nx, l_rdata_nx;
    logic              mem_E_nx, mem_RW_nx;
    logic [63:0]       mem_address_nx;
    logic [DATA_W-1:0] mem_dataIn_nx;
    logic              busy_nx;
    logic              f_cand, l_cand, arb_en, take_l;

    // Returns 1 when the loader wins; only meaningful when at least one candidate is set.
    function automatic logic pick_loader(input logic f, input logic l, input port_t last);
        if (f && l) begin
            return LOADER_PRIO ? 1'b1 : (last == PORT_F);
        end
        return l;
    endfunction

    function automatic logic [63:0] widen_addr(input logic [ADDR_W-1:0] a);
        return 64'(a);
    endfunction

    always_comb begin
        state_nx       = state;
        last_gnt_nx    = last_gnt;
        wr_nx          = wr_q;
        f_ack_nx       = 1'b0;
        l_ack_nx       = 1'b0;
        f_rdata_nx     = f_rdata;
        l_rdata_nx     = l_rdata;
        mem_E_nx       = 1'b0;
        mem_RW_nx      = 1'b0;
        mem_address_nx = mem_address;
        mem_dataIn_nx  = mem_dataIn;
        f_cand         = f_req;
        l_cand         = l_req;
        arb_en         = 1'b0;
        take_l         = 1'b0;

        case (state)
            IDLE: begin
                arb_en = 1'b1;
            end
            ISSUE: begin
                state_nx = CAPTURE;
            end
            CAPTURE: begin
                // last_gnt always names the access in flight; its port is excluded from re-arbitration
                // because its request is still held during the ack cycle.
                if (last_gnt == PORT_F) begin
                    f_ack_nx   = 1'b1;
                    f_rdata_nx = mem_dataOut;
                    f_cand     = 1'b0;
                end else begin
                    l_ack_nx = 1'b1;
                    if (!wr_q) begin
                        l_rdata_nx = mem_dataOut;
                    end
                    l_cand = 1'b0;
                end
                state_nx = IDLE;
                arb_en   = 1'b1;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (arb_en && (f_cand || l_cand)) begin
            take_l         = pick_loader(f_cand, l_cand, last_gnt);
            last_gnt_nx    = take_l ? PORT_L : PORT_F;
            wr_nx          = take_l & l_we;
            mem_E_nx       = 1'b1;
            mem_RW_nx      = take_l ? ~l_we : 1'b1;
            mem_address_nx = widen_addr(take_l ? l_addr : f_addr);
            if (take_l) begin
                mem_dataIn_nx = l_wdata;
            end
            state_nx = ISSUE;
        end

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            last_gnt    <= PORT_L;
            wr_q        <= 1'b0;
            f_ack       <= 1'b0;
            l_ack       <= 1'b0;
            f_rdata     <= '0;
            l_rdata     <= '0;
            mem_E       <= 1'b0;
            mem_RW      <= 1'b0;
            mem_address <= '0;
            mem_dataIn  <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            last_gnt    <= last_gnt_nx;
            wr_q        <= wr_nx;
            f_ack       <= f_ack_nx;
            l_ack       <= l_ack_nx;
            f_rdata     <= f_rdata_nx;
            l_rdata     <= l_rdata_nx;
            mem_E       <= mem_E_nx;
            mem_RW      <= mem_RW_nx;
            mem_address <= mem_address_nx;
            mem_dataIn  <= mem_dataIn_nx;
            busy        <= busy_nx;
        end
    end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Bench for imem_access_arbiter: round-robin instance plus a loader-priority instance,
// each backed by a registered-read memory model; reads are checked against a shadow array.
module tb_imem_access_arbiter;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 64;
    localparam logic [DATA_W-1:0] PAT  = 64'hDEAD_BEEF_0000_0001;
    localparam logic [DATA_W-1:0] PAT2 = 64'hA5A5_0000_FFFF_1234;
    localparam logic [DATA_W-1:0] OLDV = 64'h0123_4567_89AB_CDEF;
    localparam logic [DATA_W-1:0] NEWV = 64'hFEDC_BA98_7654_3210;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              f_req, l_req, l_we;
    logic [ADDR_W-1:0] f_addr, l_addr;
    logic [DATA_W-1:0] l_wdata, f_rdata, l_rdata, mem_dataIn, mem_dataOut;
    logic              f_ack, l_ack, mem_E, mem_RW, busy;
    logic [63:0]       mem_address;

    logic              p_f_req, p_l_req, p_l_we;
    logic [ADDR_W-1:0] p_f_addr, p_l_addr;
    logic [DATA_W-1:0] p_l_wdata, p_f_rdata, p_l_rdata, p_mem_dataIn, p_mem_dataOut;
    logic              p_f_ack, p_l_ack, p_mem_E, p_mem_RW, p_busy;
    logic [63:0]       p_mem_address;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] mem0 [0:1023];
    logic [DATA_W-1:0] mem1 [0:1023];
    logic [DATA_W-1:0] ref_mem [0:15];

    imem_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOADER_PRIO(1'b0)) dut (
        .Clk(clk), .Reset_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_ack(l_ack), .l_rdata(l_rdata),
        .mem_E(mem_E), .mem_RW(mem_RW), .mem_address(mem_address),
        .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut), .busy(busy)
    );

    imem_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOADER_PRIO(1'b1)) dut_prio (
        .Clk(clk), .Reset_n(rst_n),
        .f_req(p_f_req), .f_addr(p_f_addr), .f_ack(p_f_ack), .f_rdata(p_f_rdata),
        .l_req(p_l_req), .l_we(p_l_we), .l_addr(p_l_addr), .l_wdata(p_l_wdata),
        .l_ack(p_l_ack), .l_rdata(p_l_rdata),
        .mem_E(p_mem_E), .mem_RW(p_mem_RW), .mem_address(p_mem_address),
        .mem_dataIn(p_mem_dataIn), .mem_dataOut(p_mem_dataOut), .busy(p_busy)
    );

    always @(posedge clk) begin
        if (mem_E) begin
            if (!mem_RW) mem0[mem_address[ADDR_W-1:0]] <= mem_dataIn;
            else         mem_dataOut <= mem0[mem_address[ADDR_W-1:0]];
        end
    end

    always @(posedge clk) begin
        if (p_mem_E) begin
            if (!p_mem_RW) mem1[p_mem_address[ADDR_W-1:0]] <= p_mem_dataIn;
            else           p_mem_dataOut <= mem1[p_mem_address[ADDR_W-1:0]];
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic f_access(input logic [ADDR_W-1:0] a, output int lat);
        f_req = 1'b1; f_addr = a; lat = 0;
        do begin @(negedge clk); lat++; end while (f_ack !== 1'b1 && lat < 20);
        f_req = 1'b0;
    endtask

    task automatic l_access(input logic we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, output int lat);
        l_req = 1'b1; l_we = we; l_addr = a; l_wdata = d; lat = 0;
        do begin @(negedge clk); lat++; end while (l_ack !== 1'b1 && lat < 20);
        l_req = 1'b0;
    endtask

    task automatic test_reset();
        int kf, kl;
        f_req = 1'b1; f_addr = 10'd3; l_req = 1'b1; l_we = 1'b1; l_addr = 10'd9; l_wdata = 64'h1234;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({f_ack, l_ack, mem_E, mem_RW, busy} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags: got %b required 00000", {f_ack, l_ack, mem_E, mem_RW, busy}); end
        n_cmp++; if (f_rdata !== '0 || l_rdata !== '0) begin
            n_err++; $display("FAIL reset_rdata: got %0h/%0h required 0/0", f_rdata, l_rdata); end
        n_cmp++; if (mem_address !== 64'd0 || mem_dataIn !== '0) begin
            n_err++; $display("FAIL reset_mem_bus: got %0h/%0h required 0/0", mem_address, mem_dataIn); end
        n_cmp++; if ({p_f_ack, p_l_ack, p_mem_E, p_busy} !== 4'b0) begin
            n_err++; $display("FAIL reset_prio_flags: got %b required 0000", {p_f_ack, p_l_ack, p_mem_E, p_busy}); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_E !== 1'b1 || mem_RW !== 1'b1 || mem_address !== 64'd3 || busy !== 1'b1) begin
            n_err++; $display("FAIL reset_first_grant: got E=%b RW=%b addr=%0h busy=%b required 1 1 3 1",
                              mem_E, mem_RW, mem_address, busy); end
        kf = 0; kl = 0;
        for (int k = 2; k <= 12 && (f_req || l_req); k++) begin
            @(negedge clk);
            if (f_ack === 1'b1 && kf == 0) begin kf = k; f_req = 1'b0; end
            if (l_ack === 1'b1 && kl == 0) begin kl = k; l_req = 1'b0; end
        end
        f_req = 1'b0; l_req = 1'b0;
        n_cmp++; if (kf != 3) begin n_err++; $display("FAIL reset_f_ack_cycle: got %0d required 3", kf); end
        n_cmp++; if (kl != 5) begin n_err++; $display("FAIL reset_l_ack_cycle: got %0d required 5", kl); end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int lat;
        l_req = 1'b1; l_we = 1'b1; l_addr = 10'd5; l_wdata = PAT;
        @(negedge clk);
        n_cmp++; if (mem_E !== 1'b1 || mem_RW !== 1'b0 || mem_address !== 64'd5 || mem_dataIn !== PAT) begin
            n_err++; $display("FAIL wr_issue: got E=%b RW=%b addr=%0h din=%0h required 1 0 5 %0h",
                              mem_E, mem_RW, mem_address, mem_dataIn, PAT); end
        @(negedge clk);
        n_cmp++; if (mem_E !== 1'b0 || l_ack !== 1'b0) begin
            n_err++; $display("FAIL wr_issue_end: got E=%b ack=%b required 0 0", mem_E, l_ack); end
        @(negedge clk);
        n_cmp++; if (l_ack !== 1'b1) begin n_err++; $display("FAIL wr_ack: got %b required 1", l_ack); end
        l_req = 1'b0;
        n_cmp++; if (l_rdata !== '0) begin
            n_err++; $display("FAIL wr_rdata_hold: got %0h required 0", l_rdata); end
        @(negedge clk);
        n_cmp++; if (l_ack !== 1'b0) begin n_err++; $display("FAIL wr_ack_pulse: got %b required 0", l_ack); end
        f_access(10'd5, lat);
        n_cmp++; if (lat != 3) begin n_err++; $display("FAIL rd_latency: got %0d required 3", lat); end
        n_cmp++; if (f_rdata !== PAT) begin n_err++; $display("FAIL rd_data: got %0h required %0h", f_rdata, PAT); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int port_q[$];
        int time_q[$];
        int fc, lc;
        apply_reset();
        fc = 0; lc = 0;
        f_req = 1'b1; f_addr = 10'd5; l_req = 1'b1; l_we = 1'b0; l_addr = 10'd5;
        for (int k = 1; k <= 40 && port_q.size() < 6; k++) begin
            @(negedge clk);
            n_cmp++; if (f_ack === 1'b1 && l_ack === 1'b1) begin
                n_err++; $display("FAIL rr_exclusive_ack: got both acks at cycle %0d required at most one", k); end
            if (f_ack === 1'b1) begin
                port_q.push_back(0); time_q.push_back(k); fc++;
                n_cmp++; if (f_rdata !== PAT) begin n_err++; $display("FAIL rr_f_data: got %0h required %0h", f_rdata, PAT); end
                if (fc == 3) f_req = 1'b0;
            end
            if (l_ack === 1'b1) begin
                port_q.push_back(1); time_q.push_back(k); lc++;
                n_cmp++; if (l_rdata !== PAT) begin n_err++; $display("FAIL rr_l_data: got %0h required %0h", l_rdata, PAT); end
                if (lc == 3) l_req = 1'b0;
            end
        end
        f_req = 1'b0; l_req = 1'b0;
        n_cmp++; if (port_q.size() != 6) begin n_err++; $display("FAIL rr_count: got %0d required 6", port_q.size()); end
        for (int i = 0; i < port_q.size(); i++) begin
            n_cmp++; if (port_q[i] != (i % 2)) begin
                n_err++; $display("FAIL rr_order[%0d]: got port %0d required %0d", i, port_q[i], i % 2); end
            n_cmp++; if (time_q[i] != 3 + 2 * i) begin
                n_err++; $display("FAIL rr_spacing[%0d]: got cycle %0d required %0d", i, time_q[i], 3 + 2 * i); end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_loader_prio();
        int kf, kl;
        apply_reset();
        kf = 0; kl = 0;
        p_f_req = 1'b1; p_f_addr = 10'd1;
        p_l_req = 1'b1; p_l_we = 1'b1; p_l_addr = 10'd1; p_l_wdata = PAT2;
        @(negedge clk);
        n_cmp++; if (p_mem_E !== 1'b1 || p_mem_RW !== 1'b0 || p_mem_address !== 64'd1) begin
            n_err++; $display("FAIL prio_first_grant: got E=%b RW=%b addr=%0h required 1 0 1",
                              p_mem_E, p_mem_RW, p_mem_address); end
        for (int k = 2; k <= 20 && kf == 0; k++) begin
            @(negedge clk);
            if (p_l_ack === 1'b1 && kl == 0) begin kl = k; p_l_req = 1'b0; end
            if (p_f_ack === 1'b1) begin kf = k; p_f_req = 1'b0; end
        end
        p_f_req = 1'b0; p_l_req = 1'b0;
        n_cmp++; if (kl != 3) begin n_err++; $display("FAIL prio_l_ack_cycle: got %0d required 3", kl); end
        n_cmp++; if (kf != 5) begin n_err++; $display("FAIL prio_f_ack_cycle: got %0d required 5", kf); end
        n_cmp++; if (p_f_rdata !== PAT2) begin n_err++; $display("FAIL prio_f_data: got %0h required %0h", p_f_rdata, PAT2); end
        n_cmp++; if (p_l_rdata !== '0) begin n_err++; $display("FAIL prio_l_rdata_hold: got %0h required 0", p_l_rdata); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        int lat;
        logic [DATA_W-1:0] d;
        logic f_done, l_done;
        for (int a = 0; a < 16; a++) begin
            d = {$urandom(), $urandom()};
            l_access(1'b1, ADDR_W'(a), d, lat);
            ref_mem[a] = d;
            n_cmp++; if (lat != 3) begin n_err++; $display("FAIL preload_latency[%0d]: got %0d required 3", a, lat); end
        end
        f_done = 1'b0; l_done = 1'b0;
        fork
            begin : req_f
                for (int i = 0; i < 25; i++) begin
                    int flat;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    f_addr = ADDR_W'($urandom_range(0, 15)); f_req = 1'b1; flat = 0;
                    do begin @(negedge clk); flat++; end while (f_ack !== 1'b1 && flat < 20);
                    f_req = 1'b0;
                    n_cmp++; if (flat < 3 || flat > 5) begin
                        n_err++; $display("FAIL rnd_f_latency: got %0d required 3..5", flat); end
                end
                f_done = 1'b1;
            end
            begin : req_l
                for (int j = 0; j < 25; j++) begin
                    int llat;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    l_we = 1'($urandom_range(0, 1)); l_addr = ADDR_W'($urandom_range(0, 15));
                    l_wdata = {$urandom(), $urandom()}; l_req = 1'b1; llat = 0;
                    do begin @(negedge clk); llat++; end while (l_ack !== 1'b1 && llat < 20);
                    l_req = 1'b0;
                    n_cmp++; if (llat < 3 || llat > 5) begin
                        n_err++; $display("FAIL rnd_l_latency: got %0d required 3..5", llat); end
                end
                l_done = 1'b1;
            end
            begin : mon
                int cyc;
                logic prev_e;
                cyc = 0; prev_e = 1'b0;
                while (!(f_done && l_done) && cyc < 3000) begin
                    @(negedge clk); cyc++;
                    n_cmp++; if (f_ack === 1'b1 && l_ack === 1'b1) begin
                        n_err++; $display("FAIL rnd_exclusive_ack: got both acks required at most one"); end
                    n_cmp++; if (prev_e === 1'b1 && mem_E === 1'b1) begin
                        n_err++; $display("FAIL rnd_mem_E_run: got mem_E high two cycles required single cycle"); end
                    prev_e = mem_E;
                    if (f_ack === 1'b1) begin
                        n_cmp++; if (f_rdata !== ref_mem[f_addr[3:0]]) begin
                            n_err++; $display("FAIL rnd_f_data @%0d: got %0h required %0h", f_addr, f_rdata, ref_mem[f_addr[3:0]]); end
                    end
                    if (l_ack === 1'b1) begin
                        if (l_we) ref_mem[l_addr[3:0]] = l_wdata;
                        else begin
                            n_cmp++; if (l_rdata !== ref_mem[l_addr[3:0]]) begin
                                n_err++; $display("FAIL rnd_l_data @%0d: got %0h required %0h", l_addr, l_rdata, ref_mem[l_addr[3:0]]); end
                        end
                    end
                end
                n_cmp++; if (!(f_done && l_done)) begin
                    n_err++; $display("FAIL rnd_timeout: got done=%b%b required 11", f_done, l_done); end
            end
        join
        repeat (2) @(negedge clk);
    endtask

    task automatic test_same_port();
        int cnt;
        cnt = 0;
        f_req = 1'b1; f_addr = 10'd0;
        for (int k = 1; k <= 20 && cnt < 3; k++) begin
            @(negedge clk);
            if (f_ack === 1'b1) begin
                n_cmp++; if (k != 3 * (cnt + 1)) begin
                    n_err++; $display("FAIL same_port_spacing[%0d]: got cycle %0d required %0d", cnt, k, 3 * (cnt + 1)); end
                n_cmp++; if (f_rdata !== ref_mem[cnt]) begin
                    n_err++; $display("FAIL same_port_data[%0d]: got %0h required %0h", cnt, f_rdata, ref_mem[cnt]); end
                n_cmp++; if (mem_E !== 1'b0 || busy !== 1'b0) begin
                    n_err++; $display("FAIL same_port_no_dup: got E=%b busy=%b required 0 0", mem_E, busy); end
                cnt++;
                if (cnt == 3) f_req = 1'b0;
                else          f_addr = ADDR_W'(cnt);
            end
        end
        f_req = 1'b0;
        n_cmp++; if (cnt != 3) begin n_err++; $display("FAIL same_port_count: got %0d required 3", cnt); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, kf, kl;
        logic seen;
        l_access(1'b1, 10'd7, OLDV, lat);
        n_cmp++; if (lat != 3) begin n_err++; $display("FAIL abort_setup_latency: got %0d required 3", lat); end
        l_req = 1'b1; l_we = 1'b1; l_addr = 10'd7; l_wdata = NEWV;
        @(negedge clk);
        n_cmp++; if (mem_E !== 1'b1 || mem_RW !== 1'b0) begin
            n_err++; $display("FAIL abort_issue: got E=%b RW=%b required 1 0", mem_E, mem_RW); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_E !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL abort_async: got E=%b busy=%b required 0 0", mem_E, busy); end
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (l_ack === 1'b1) seen = 1'b1; end
        n_cmp++; if (seen) begin n_err++; $display("FAIL abort_no_ack: got ack=1 required 0"); end
        f_req = 1'b1; f_addr = 10'd7;
        rst_n = 1'b1;
        kf = 0; kl = 0;
        for (int k = 1; k <= 15 && (f_req || l_req); k++) begin
            @(negedge clk);
            if (f_ack === 1'b1 && kf == 0) begin
                kf = k; f_req = 1'b0;
                n_cmp++; if (f_rdata !== OLDV) begin
                    n_err++; $display("FAIL abort_not_written: got %0h required %0h", f_rdata, OLDV); end
            end
            if (l_ack === 1'b1 && kl == 0) begin kl = k; l_req = 1'b0; end
        end
        f_req = 1'b0; l_req = 1'b0;
        n_cmp++; if (kf != 3 || kl != 5) begin
            n_err++; $display("FAIL abort_retry_cycles: got f=%0d l=%0d required 3 5", kf, kl); end
        @(negedge clk);
        f_access(10'd7, lat);
        n_cmp++; if (f_rdata !== NEWV || lat != 3) begin
            n_err++; $display("FAIL abort_readback: got %0h lat %0d required %0h lat 3", f_rdata, lat, NEWV); end
    endtask

    initial begin
        rst_n = 1'b0;
        f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
        p_f_req = 1'b0; p_f_addr = '0; p_l_req = 1'b0; p_l_we = 1'b0; p_l_addr = '0; p_l_wdata = '0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_round_robin();
        test_loader_prio();
        test_random();
        test_same_port();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
